// File: rtl/median_ctrl.sv
// Sequencing controller for the N-register compare-exchange median datapath.
// Counts the pixel burst, then steps BYP through compare passes and max-drops.
module median_ctrl #(
  parameter int NUM_REGISTERS = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dsi,
  output logic       o_byp,
  output logic       o_dso,
  output logic       o_busy,
  output logic [1:0] o_state
);

  localparam int PASS_LEN = NUM_REGISTERS - 1;
  localparam int DROPS    = (NUM_REGISTERS - 1) / 2;
  localparam int CNT_W    = $clog2(NUM_REGISTERS);
  localparam int IDX_W    = $clog2(DROPS + 1);

  localparam logic [CNT_W-1:0] LCNT_LAST = CNT_W'(NUM_REGISTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PASS_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_DROPS = IDX_W'(DROPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_pass_idx;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_lcnt_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_pass_idx_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_lcnt     <= '0;
      r_cnt      <= '0;
      r_pass_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pass_idx <= w_pass_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lcnt_nxt     = r_lcnt;
    w_cnt_nxt      = r_cnt;
    w_pass_idx_nxt = r_pass_idx;
    case (r_state)
      S_IDLE: begin
        // Any gap in the strobe aborts a partial window.
        if (i_dsi) begin
          if (r_lcnt == LCNT_LAST) begin
            w_state_nxt    = S_PASS;
            w_lcnt_nxt     = '0;
            w_cnt_nxt      = '0;
            w_pass_idx_nxt = '0;
          end else begin
            w_lcnt_nxt = r_lcnt + 1'b1;
          end
        end else begin
          w_lcnt_nxt = '0;
        end
      end
      S_PASS: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_pass_idx < IDX_DROPS) ? S_DROP : S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DROP: begin
        w_pass_idx_nxt = r_pass_idx + 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = S_PASS;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register.
  assign o_byp   = (r_state != S_PASS);
  assign o_dso   = (r_state == S_DONE);
  assign o_busy  = (r_state != S_IDLE);
  assign o_state = r_state;

endmodule

// File: tb/tb_median_ctrl.sv
// Bench for median_ctrl with a behavioural 9-register compare-exchange datapath.
// Expected medians and DSO cycles go into scoreboard queues as windows are driven.
module tb_median_ctrl;

  logic       clk;
  logic       rst;
  logic       dsi;
  logic [7:0] di;
  logic       o_byp;
  logic       o_dso;
  logic       o_busy;
  logic [1:0] o_state;

  median_ctrl #(.NUM_REGISTERS(9)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_dsi   (dsi),
    .o_byp   (o_byp),
    .o_dso   (o_dso),
    .o_busy  (o_busy),
    .o_state (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: BYP=1 shifts DI in; BYP=0 rotates the ring with the
  // larger of the last two registers kept in the last register.
  logic [7:0] dp [9];
  always @(posedge clk) begin
    if (o_byp) begin
      for (int i = 8; i > 0; i--) dp[i] <= dp[i-1];
      dp[0] <= di;
    end else begin
      for (int i = 7; i > 0; i--) dp[i] <= dp[i-1];
      dp[0] <= (dp[7] < dp[8]) ? dp[7] : dp[8];
      dp[8] <= (dp[7] < dp[8]) ? dp[8] : dp[7];
    end
  end

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         last_dso_cyc = 0;
  int         prev_dso_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_dso) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_dso actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        chk("dso_median", int'(dp[8]), int'(exp_q.pop_front()));
        chk("dso_cycle", cyc, exp_cyc_q.pop_front());
      end
      prev_dso_cyc = last_dso_cyc;
      last_dso_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst) assert (!(dsi && o_busy)) else $error("DSI asserted while controller busy");
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dsi = 1'b0;
      di  = 8'd0;
    end
  endtask

  // Returns just before the edge that samples the 9th pixel.
  task automatic send_window(input logic [7:0] px [9], input logic [7:0] med, input bit push);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      dsi = 1'b1;
      di  = px[i];
    end
    if (push) begin
      exp_q.push_back(med);
      exp_cyc_q.push_back(cyc + 1 + 44);
    end
  endtask

  function automatic logic [7:0] median9(input logic [7:0] px [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = px;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  typedef struct {
    logic [7:0] px [9];
    logic [7:0] med;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] w [9];
  logic [7:0] w2 [9];
  int exp_byp;

  initial begin
    vecs[0].px = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};       vecs[0].med = 8'd5;
    vecs[1].px = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};       vecs[1].med = 8'd4;
    vecs[2].px = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    vecs[2].med = 8'd255;
    vecs[3].px = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};       vecs[3].med = 8'd9;

    // Reset values and a quiet idle stretch
    rst = 1'b1; dsi = 1'b0; di = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_byp", int'(o_byp), 1);
    chk("reset_dso", int'(o_dso), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_state", int'(o_state), 0);
    rst = 1'b0;
    idle(100);
    chk("idle_busy", int'(o_busy), 0);

    // Single window with a bit-exact BYP schedule check
    send_window(vecs[0].px, vecs[0].med, 1);
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      dsi = 1'b0; di = 8'd0;
      exp_byp = (k >= 44) ? 1 : ((k % 9 == 8) ? 1 : 0);
      chk($sformatf("byp_seq[%0d]", k), int'(o_byp), exp_byp);
    end
    idle(5);

    // Table-driven windows
    for (int v = 1; v < 4; v++) begin
      send_window(vecs[v].px, vecs[v].med, 1);
      idle(60);
    end

    // Random windows against a sorting reference
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
      send_window(w, median9(w), 1);
      idle(60);
    end

    // Aborted 5-pixel burst, one gap cycle, then a full window
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dsi = 1'b1; di = 8'(200 + i);
    end
    @(negedge clk);
    dsi = 1'b0; di = 8'd0;
    chk("abort_busy", int'(o_busy), 0);
    for (int i = 0; i < 9; i++) w[i] = 8'(10 * (i + 1));
    send_window(w, 8'd50, 1);
    idle(60);

    // Back-to-back windows: second starts in the first IDLE cycle after DONE
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++) w2[i] = 8'($urandom_range(0, 255));
    send_window(w, median9(w), 1);
    idle(45);
    send_window(w2, median9(w2), 1);
    idle(60);
    chk("b2b_spacing", last_dso_cyc - prev_dso_cyc, 54);

    // Reset during the third compare pass
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    send_window(w, median9(w), 0);
    idle(22);
    chk("midsort_busy_before", int'(o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midsort_busy_after", int'(o_busy), 0);
    chk("midsort_state_after", int'(o_state), 0);
    idle(60);
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    send_window(w, median9(w), 1);
    idle(60);

    // Bounded drain of anything still expected
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
    while (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_dso actual=none expected_median=%0d", exp_q.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
